// File: rtl/dcm_pkg.sv
// Shared constants, types and helpers for the multi-channel clock-division manager.
package dcm_pkg;

  localparam int unsigned DEF_N_CH      = 2;
  localparam int unsigned DEF_SEL_W     = 3;
  localparam int unsigned DEF_FAST_HALF = 5;
  localparam int unsigned DEF_RESET_SEL = 0;

  typedef enum logic {
    StIdle = 1'b0,
    StPend = 1'b1
  } req_state_e;

  // Slow counter must hold 2^(2^sel_w - 1) - 1 for the largest selector.
  function automatic int unsigned scnt_w(input int unsigned sel_w);
    return (32'd1 << sel_w) - 32'd1;
  endfunction

endpackage

// File: rtl/dcm_chan_div.sv
// One slow channel: holds its ratio selector and divides fast_rise events by 2^(sel+1).
module dcm_chan_div
  import dcm_pkg::*;
#(
  parameter int unsigned SEL_W     = DEF_SEL_W,
  parameter int unsigned RESET_SEL = DEF_RESET_SEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fast_rise,
  input  logic             load,
  input  logic [SEL_W-1:0] load_val,
  output logic             rise_now,
  output logic             clk_2,
  output logic [SEL_W-1:0] sel
);

  localparam int unsigned SCNT_W = scnt_w(SEL_W);

  logic [SCNT_W-1:0] scnt_q;
  logic [SCNT_W-1:0] term;
  logic [SEL_W-1:0]  sel_q;
  logic              clk_2_q;
  logic              wrap;

  // For the largest selector the shift overflows to 0 and the subtract yields all ones.
  assign term     = (SCNT_W'(1) << sel_q) - SCNT_W'(1);
  assign wrap     = fast_rise && (scnt_q == term);
  assign rise_now = wrap && !clk_2_q;
  assign clk_2    = clk_2_q;
  assign sel      = sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q  <= '0;
      clk_2_q <= 1'b0;
      sel_q   <= SEL_W'(RESET_SEL);
    end else begin
      if (fast_rise) begin
        if (wrap) begin
          scnt_q  <= '0;
          clk_2_q <= ~clk_2_q;
        end else begin
          scnt_q <= scnt_q + SCNT_W'(1);
        end
      end
      if (load) begin
        sel_q  <= load_val;
        scnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/dcm_multi.sv
// Fast divider plus N_CH programmable slow channels; ratio updates land on a rising boundary.
module dcm_multi
  import dcm_pkg::*;
#(
  parameter int unsigned N_CH      = DEF_N_CH,
  parameter int unsigned SEL_W     = DEF_SEL_W,
  parameter int unsigned FAST_HALF = DEF_FAST_HALF,
  parameter int unsigned RESET_SEL = DEF_RESET_SEL,
  localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      prog_in,
  input  logic [CH_W-1:0]       ch_sel,
  input  logic                  update,
  output logic                  busy,
  output logic                  clk_1,
  output logic [N_CH-1:0]       clk_2,
  output logic [N_CH*SEL_W-1:0] prog_out
);

  localparam int unsigned FCNT_W = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;

  logic [FCNT_W-1:0] fcnt_q;
  logic              clk_1_q;
  logic              fast_tc;
  logic              fast_rise;

  req_state_e        state_q;
  logic [CH_W-1:0]   pend_ch_q;
  logic [SEL_W-1:0]  pend_val_q;
  logic              accept;
  logic [N_CH-1:0]   rise_now;
  logic [N_CH-1:0]   load;

  assign fast_tc   = (fcnt_q == FCNT_W'(FAST_HALF - 1));
  assign fast_rise = fast_tc && !clk_1_q;
  assign clk_1     = clk_1_q;
  assign busy      = (state_q == StPend);
  assign accept    = update && (32'(ch_sel) < N_CH);

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      clk_1_q <= 1'b0;
    end else if (fast_tc) begin
      fcnt_q  <= '0;
      clk_1_q <= ~clk_1_q;
    end else begin
      fcnt_q <= fcnt_q + FCNT_W'(1);
    end
  end

  // Requests arriving while one is pending are dropped, not queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pend_ch_q  <= '0;
      pend_val_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            pend_ch_q  <= ch_sel;
            pend_val_q <= prog_in;
            state_q    <= StPend;
          end
        end
        StPend: begin
          if (|load) state_q <= StIdle;
        end
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    assign load[c] = (state_q == StPend) && (pend_ch_q == CH_W'(c)) && rise_now[c];

    dcm_chan_div #(
      .SEL_W    (SEL_W),
      .RESET_SEL(RESET_SEL)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .fast_rise(fast_rise),
      .load     (load[c]),
      .load_val (pend_val_q),
      .rise_now (rise_now[c]),
      .clk_2    (clk_2[c]),
      .sel      (prog_out[c*SEL_W +: SEL_W])
    );
  end

endmodule

// File: tb/tb_dcm_multi.sv
// Randomised self-checking bench for dcm_multi against a closed-form timing model.
module tb_dcm_multi;

  localparam int NCH = 3;
  localparam int FH  = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           update = 1'b0;
  logic [1:0]     ch_sel = '0;
  logic [2:0]     prog_in = '0;
  logic           busy;
  logic           clk_1;
  logic [NCH-1:0] clk_2;
  logic [3*NCH-1:0] prog_out;

  logic [0:0]     ch_sel7 = '0;
  logic [2:0]     prog_in7 = '0;
  logic           update7 = 1'b0;
  logic           busy7;
  logic           clk_1_7;
  logic [0:0]     clk_2_7;
  logic [2:0]     prog_out7;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: edge count t, fast-rise count k, per-channel anchor (a_m, base_m) and selector.
  int t, k, pend, pend_ch, pend_val;
  int sel_m[NCH];
  int a_m[NCH];
  int base_m[NCH];

  dcm_multi #(.N_CH(NCH), .SEL_W(3), .FAST_HALF(FH), .RESET_SEL(0)) dut (
    .clk(clk), .rst(rst), .prog_in(prog_in), .ch_sel(ch_sel), .update(update),
    .busy(busy), .clk_1(clk_1), .clk_2(clk_2), .prog_out(prog_out)
  );

  dcm_multi #(.N_CH(1), .SEL_W(3), .FAST_HALF(FH), .RESET_SEL(7)) dut7 (
    .clk(clk), .rst(rst), .prog_in(prog_in7), .ch_sel(ch_sel7), .update(update7),
    .busy(busy7), .clk_1(clk_1_7), .clk_2(clk_2_7), .prog_out(prog_out7)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, t);
    end
  endtask

  function automatic int lvl(input int c, input int kk);
    return base_m[c] ^ (((kk - a_m[c]) >> sel_m[c]) & 1);
  endfunction

  task automatic model_reset();
    t = 0; k = 0; pend = 0; pend_ch = 0; pend_val = 0;
    for (int c = 0; c < NCH; c++) begin
      sel_m[c] = 0; a_m[c] = 0; base_m[c] = 0;
    end
  endtask

  task automatic tick(input bit r, input bit u, input int ch, input int v);
    int pb, lv_old, lv_new;
    logic [3*NCH-1:0] exp_po;
    lv_old = 0; lv_new = 0;
    rst = r; update = u; ch_sel = 2'(ch); prog_in = 3'(v);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      pb = pend;
      t++;
      if ((t % (2*FH)) == FH) begin
        if (pb != 0) begin
          lv_old = lvl(pend_ch, k);
          lv_new = lvl(pend_ch, k + 1);
        end
        k++;
        if (pb != 0 && lv_old == 0 && lv_new == 1) begin
          sel_m[pend_ch] = pend_val; a_m[pend_ch] = k; base_m[pend_ch] = 1; pend = 0;
        end
      end
      if (pb == 0 && u && ch < NCH) begin
        pend = 1; pend_ch = ch; pend_val = v;
      end
    end
    #1;
    exp_po = '0;
    for (int c = 0; c < NCH; c++) begin
      exp_po[c*3 +: 3] = 3'(sel_m[c]);
      check_eq($sformatf("clk_2[%0d]", c), 32'(clk_2[c]), lvl(c, k));
    end
    check_eq("clk_1", 32'(clk_1), (t / FH) % 2);
    check_eq("busy", 32'(busy), pend);
    check_eq("prog_out", 32'(prog_out), 32'(exp_po));
    check_eq("r7_clk_2", 32'(clk_2_7), (k >> 7) & 1);
    check_eq("r7_clk_1", 32'(clk_1_7), (t / FH) % 2);
    check_eq("r7_prog_out", 32'(prog_out7), 7);
    check_eq("r7_busy", 32'(busy7), 0);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) tick(1, 0, 0, 0);
    repeat (63) tick(0, 0, 0, 0);

    // Reprogram ch1 mid-period, then a request while busy must be dropped.
    tick(0, 1, 1, 3);
    check_eq("busy_after_accept", 32'(busy), 1);
    tick(0, 1, 0, 2);
    repeat (400) tick(0, 0, 0, 0);
    check_eq("ch1_applied", 32'(prog_out[5:3]), 3);
    check_eq("ch0_untouched", 32'(prog_out[2:0]), 0);

    tick(0, 1, 3, 5);
    check_eq("oob_busy", 32'(busy), 0);

    // Reset while a request is pending loses it.
    tick(0, 1, 0, 4);
    check_eq("pend_busy", 32'(busy), 1);
    tick(1, 0, 0, 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_prog_out", 32'(prog_out), 0);
    repeat (200) tick(0, 0, 0, 0);
    check_eq("lost_request", 32'(prog_out[2:0]), 0);

    // Request accepted on the very edge of a ch0 rising toggle waits a full period.
    n = 0;
    while (!(((t + 1) % (2*FH)) == FH && lvl(0, k) == 0 && lvl(0, k + 1) == 1) && n < 100) begin
      tick(0, 0, 0, 0);
      n++;
    end
    check_eq("align_found", 32'(n < 100), 1);
    tick(0, 1, 0, 1);
    check_eq("same_edge_no_apply", 32'(prog_out[2:0]), 0);
    repeat (100) tick(0, 0, 0, 0);

    // Maximum ratio on ch2; also lets the RESET_SEL=7 instance reach its first rise.
    tick(0, 1, 2, 7);
    repeat (6000) tick(0, 0, 0, 0);
    check_eq("ch2_max_applied", 32'(prog_out[8:6]), 7);

    tick(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      int len;
      tick($urandom_range(0, 19) == 0, 1, $urandom_range(0, 3),
           ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(0, 7));
      len = $urandom_range(20, 400);
      for (int j = 0; j < len; j++)
        tick(0, $urandom_range(0, 29) == 0, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
